csr_unit: RTL and testbench
===========================

# csr_unit

Parametrised machine-mode CSR unit for the scr1 core: decodes CSRRW/CSRRS/CSRRC accesses, holds the machine trap-handling registers, and runs free-running 64-bit cycle and retired-instruction counters. It also performs hardware trap entry and MRET updates, and exports interrupt-pending and trap-vector state to the pipeline. It sits beside the execute stage, which issues one-cycle requests and receives a registered response.

## Interface
- XLEN, 32: data width; only 32 supported for the counter high halves.
- HART_ID, 0: value returned by mhartid (0xF14).
- MISA_VAL, 32'h4000_0100: value returned by misa (0x301), RV32I.
- VENDOR_ID, 0: value returned by mvendorid; marchid and mimpid read 0.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- csr_req_i  in  1  access request, sampled each edge.
- csr_op_i  in  2  00 read, 01 RW, 10 set, 11 clear.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  XLEN  write operand or mask.
- csr_rdata_o  out  XLEN  old CSR value, registered.
- csr_valid_o  out  1  response strobe, one cycle after the request.
- csr_illegal_o  out  1  illegal-access strobe, concurrent with csr_valid_o.
- instret_i  in  1  one instruction retired this cycle.
- trap_i  in  1  trap entry.
- trap_cause_i  in  XLEN  mcause value on trap.
- trap_pc_i  in  XLEN  mepc value on trap.
- mret_i  in  1  MRET retire.
- ext_irq_i, timer_irq_i, soft_irq_i  in  1 each  interrupt lines, mirrored into mip bits 11, 7 and 3.
- irq_pending_o  out  1  mstatus.MIE & |(mip & mie), registered.
- mtvec_o, mepc_o  out  XLEN  current register contents.

## Operation
- Implemented CSRs: misa, mvendorid, marchid, mimpid, mhartid, mstatus (0x300), mie (0x304), mtvec (0x305), mcounteren (0x306), mscratch (0x340), mepc (0x341), mcause (0x342), mip (0x344), mcycle/mcycleh (0xB00/0xB80), minstret/minstreth (0xB02/0xB82).
- New value per op:
  - RW: wdata.
  - Set: old | wdata.
  - Clear: old & ~wdata.
  - Read (00): no write.
- Field masking:
  - mstatus: only MIE (bit 3) and MPIE (bit 7) are writable; MPP (12:11) reads 2'b11; all other bits read 0.
  - mie: only bits 11, 7 and 3 are writable.
  - mtvec: bit 1 is forced to 0.
  - mepc: bits 1:0 are forced to 0.
  - mip, misa and the ID registers ignore writes (the access is legal).
- Illegal access (response rdata 0, csr_illegal_o=1, no state change) when either holds:
  - the address is unimplemented;
  - the op is not 00 and addr[11:10]==2'b11.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instret_i=1.
  - Each counter is 64-bit; the carry from the low half propagates to the high half in the same cycle.
  - A software write to either half overrides that half's increment in that cycle; the other half still increments or carries normally.
- Trap entry (trap_i):
  - mepc <= trap_pc_i & ~3; mcause <= trap_cause_i.
  - MPIE <= MIE; MIE <= 0.
- MRET (mret_i): MIE <= MPIE; MPIE <= 1.
- Priority: trap_i > mret_i > CSR write.
  - A CSR write coinciding with trap_i or mret_i is dropped.
  - The read still returns the pre-edge value with csr_valid_o=1.

## Timing
- Reset values:
  - All CSR state 0, except mstatus.MPP reads 2'b11.
  - csr_rdata_o=0, csr_valid_o=0, csr_illegal_o=0, irq_pending_o=0.
- Reset is asynchronous: asserting rst_i mid-access clears everything immediately; no response is produced for an in-flight request.
- Latency:
  - csr_valid_o and csr_rdata_o appear one cycle after the csr_req_i edge; the strobe lasts one cycle.
  - Back-to-back requests are accepted every cycle.
- Read data is the value before that edge's write or increment. Reading mcycle returns the count sampled at the request edge.
- A write is visible to a request issued on the following edge.
- irq_pending_o lags its inputs by one cycle.
- Counter wrap: 0xFFFF_FFFF_FFFF_FFFF increments to 0.

## Configuration
- CSR_COUNTERS_EN
  - Defined: mcycle, mcycleh, minstret and minstreth are implemented as described above.
  - Undefined: those four addresses remain legal, read 0 and ignore writes; no counter flops are synthesised.

## Test plan
- Reset, then RW 0x340 with 0xDEADBEEF, then read 0x340 -> first response rdata 0; read response 0xDEADBEEF, valid for 1 cycle.
- mstatus=0x8 (MIE=1), then pulse trap_i with cause 0x8000000B and pc 0x1003 -> mepc=0x1000, mcause=0x8000000B, mstatus reads 0x1880; then mret_i -> mstatus reads 0x1888.
- RW 0xF14 and read 0x7C0 -> csr_illegal_o=1 and rdata 0 on both; read 0xF14 -> HART_ID, no illegal.
- Write mcycle=0xFFFFFFFF and mcycleh=0, then wait 2 cycles and read mcycleh -> 1, and mcycle has wrapped to 0x1 (CSR_COUNTERS_EN defined).
- Set mie bit 11, mstatus.MIE=1, raise ext_irq_i -> irq_pending_o=1 one cycle later; clear mie with op 11 and mask 0x800 -> irq_pending_o=0.
- RW to 0x341 in the same cycle as trap_i -> mepc holds trap_pc_i, not the CSR data.

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSRRW/S/C decode, trap/MRET state, interrupt pending, 64-bit counters.
// Optional feature: define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise they read 0.
module csr_unit #(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] HART_ID   = 32'h0,
   parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
   parameter logic [31:0] VENDOR_ID = 32'h0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            csr_req_i,
   input  logic [1:0]      csr_op_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            csr_valid_o,
   output logic            csr_illegal_o,
   input  logic            instret_i,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            mret_i,
   input  logic            ext_irq_i,
   input  logic            timer_irq_i,
   input  logic            soft_irq_i,
   output logic            irq_pending_o,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mepc_o
);

   localparam logic [1:0]  OP_READ      = 2'b00;
   localparam logic [1:0]  OP_RW        = 2'b01;
   localparam logic [1:0]  OP_SET       = 2'b10;
   localparam logic [11:0] A_MSTATUS    = 12'h300;
   localparam logic [11:0] A_MISA       = 12'h301;
   localparam logic [11:0] A_MIE        = 12'h304;
   localparam logic [11:0] A_MTVEC      = 12'h305;
   localparam logic [11:0] A_MCOUNTEREN = 12'h306;
   localparam logic [11:0] A_MSCRATCH   = 12'h340;
   localparam logic [11:0] A_MEPC       = 12'h341;
   localparam logic [11:0] A_MCAUSE     = 12'h342;
   localparam logic [11:0] A_MIP        = 12'h344;
   localparam logic [11:0] A_MCYCLE     = 12'hB00;
   localparam logic [11:0] A_MINSTRET   = 12'hB02;
   localparam logic [11:0] A_MCYCLEH    = 12'hB80;
   localparam logic [11:0] A_MINSTRETH  = 12'hB82;
   localparam logic [11:0] A_MVENDORID  = 12'hF11;
   localparam logic [11:0] A_MARCHID    = 12'hF12;
   localparam logic [11:0] A_MIMPID     = 12'hF13;
   localparam logic [11:0] A_MHARTID    = 12'hF14;
   localparam logic [XLEN-1:0] MIE_MASK = XLEN'(32'h0000_0888);

   logic            r_mstatus_mie;
   logic            r_mstatus_mpie;
   logic [XLEN-1:0] r_mie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mcounteren;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_rdata;
   logic            r_valid;
   logic            r_illegal;
   logic            r_irq;

   logic [XLEN-1:0] w_mip;
   logic [XLEN-1:0] w_mstatus;
   logic [XLEN-1:0] w_old;
   logic [XLEN-1:0] w_new;
   logic            w_hit;
   logic            w_illegal;
   logic            w_wr;
   logic [XLEN-1:0] w_cyc_lo, w_cyc_hi, w_ins_lo, w_ins_hi;

   // Read mux and address decode
   always_comb begin
      w_mip        = '0;
      w_mip[11]    = ext_irq_i;
      w_mip[7]     = timer_irq_i;
      w_mip[3]     = soft_irq_i;
      w_mstatus    = XLEN'({2'b11, 3'b000, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000});
      w_hit        = 1'b1;
      w_old        = '0;
      case (csr_addr_i)
         A_MSTATUS:    w_old = w_mstatus;
         A_MISA:       w_old = XLEN'(MISA_VAL);
         A_MIE:        w_old = r_mie;
         A_MTVEC:      w_old = r_mtvec;
         A_MCOUNTEREN: w_old = r_mcounteren;
         A_MSCRATCH:   w_old = r_mscratch;
         A_MEPC:       w_old = r_mepc;
         A_MCAUSE:     w_old = r_mcause;
         A_MIP:        w_old = w_mip;
         A_MCYCLE:     w_old = w_cyc_lo;
         A_MCYCLEH:    w_old = w_cyc_hi;
         A_MINSTRET:   w_old = w_ins_lo;
         A_MINSTRETH:  w_old = w_ins_hi;
         A_MVENDORID:  w_old = XLEN'(VENDOR_ID);
         A_MARCHID:    w_old = '0;
         A_MIMPID:     w_old = '0;
         A_MHARTID:    w_old = XLEN'(HART_ID);
         default:      w_hit = 1'b0;
      endcase
      case (csr_op_i)
         OP_RW:   w_new = csr_wdata_i;
         OP_SET:  w_new = w_old | csr_wdata_i;
         OP_READ: w_new = w_old;
         default: w_new = w_old & ~csr_wdata_i;
      endcase
      w_illegal = !w_hit || ((csr_op_i != OP_READ) && (csr_addr_i[11:10] == 2'b11));
      w_wr      = csr_req_i && !w_illegal && (csr_op_i != OP_READ) && !trap_i && !mret_i;
   end

   // Trap-handling registers and registered response; trap beats MRET beats software write
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie          <= '0;
         r_mtvec        <= '0;
         r_mcounteren   <= '0;
         r_mscratch     <= '0;
         r_mepc         <= '0;
         r_mcause       <= '0;
         r_rdata        <= '0;
         r_valid        <= 1'b0;
         r_illegal      <= 1'b0;
         r_irq          <= 1'b0;
      end else begin
         r_valid   <= csr_req_i;
         r_illegal <= csr_req_i & w_illegal;
         if (csr_req_i) r_rdata <= w_illegal ? '0 : w_old;
         r_irq     <= r_mstatus_mie & (|(w_mip & r_mie));
         if (trap_i) begin
            r_mepc         <= trap_pc_i & ~XLEN'(3);
            r_mcause       <= trap_cause_i;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
         end else if (mret_i) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end else if (w_wr) begin
            case (csr_addr_i)
               A_MSTATUS: begin
                  r_mstatus_mie  <= w_new[3];
                  r_mstatus_mpie <= w_new[7];
               end
               A_MIE:        r_mie        <= w_new & MIE_MASK;
               A_MTVEC:      r_mtvec      <= w_new & ~XLEN'(2);
               A_MCOUNTEREN: r_mcounteren <= w_new;
               A_MSCRATCH:   r_mscratch   <= w_new;
               A_MEPC:       r_mepc       <= w_new & ~XLEN'(3);
               A_MCAUSE:     r_mcause     <= w_new;
               default:      ;
            endcase
         end
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [XLEN-1:0] r_cyc_lo, r_cyc_hi, r_ins_lo, r_ins_hi;
   logic            w_wr_cyc_lo, w_wr_cyc_hi, w_wr_ins_lo, w_wr_ins_hi;
   logic            w_cyc_carry, w_ins_carry;

   assign w_wr_cyc_lo = w_wr && (csr_addr_i == A_MCYCLE);
   assign w_wr_cyc_hi = w_wr && (csr_addr_i == A_MCYCLEH);
   assign w_wr_ins_lo = w_wr && (csr_addr_i == A_MINSTRET);
   assign w_wr_ins_hi = w_wr && (csr_addr_i == A_MINSTRETH);
   assign w_cyc_carry = &r_cyc_lo;
   assign w_ins_carry = instret_i & (&r_ins_lo);

   // A written half takes the software value; the other half keeps counting/carrying
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cyc_lo <= '0;
         r_cyc_hi <= '0;
         r_ins_lo <= '0;
         r_ins_hi <= '0;
      end else begin
         r_cyc_lo <= w_wr_cyc_lo ? w_new : r_cyc_lo + XLEN'(1);
         r_cyc_hi <= w_wr_cyc_hi ? w_new : r_cyc_hi + XLEN'(w_cyc_carry);
         r_ins_lo <= w_wr_ins_lo ? w_new : r_ins_lo + XLEN'(instret_i);
         r_ins_hi <= w_wr_ins_hi ? w_new : r_ins_hi + XLEN'(w_ins_carry);
      end
   end

   assign w_cyc_lo = r_cyc_lo;
   assign w_cyc_hi = r_cyc_hi;
   assign w_ins_lo = r_ins_lo;
   assign w_ins_hi = r_ins_hi;
`else
   logic w_unused_instret;
   assign w_unused_instret = instret_i;
   assign w_cyc_lo = '0;
   assign w_cyc_hi = '0;
   assign w_ins_lo = '0;
   assign w_ins_hi = '0;
`endif

   assign csr_rdata_o   = r_rdata;
   assign csr_valid_o   = r_valid;
   assign csr_illegal_o = r_illegal;
   assign irq_pending_o = r_irq;
   assign mtvec_o       = r_mtvec;
   assign mepc_o        = r_mepc;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit; counter checks follow CSR_COUNTERS_EN.
module tb_csr_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_req;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_valid;
   logic        csr_illegal;
   logic        instret;
   logic        trap;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic        mret;
   logic        ext_irq, timer_irq, soft_irq;
   logic        irq_pending;
   logic [31:0] mtvec, mepc;

   int n_tests = 0;
   int n_fail  = 0;

   csr_unit #(.XLEN(32), .HART_ID(32'h0), .MISA_VAL(32'h4000_0100), .VENDOR_ID(32'h0)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .csr_req_i(csr_req), .csr_op_i(csr_op), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
      .csr_rdata_o(csr_rdata), .csr_valid_o(csr_valid), .csr_illegal_o(csr_illegal),
      .instret_i(instret), .trap_i(trap), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
      .mret_i(mret), .ext_irq_i(ext_irq), .timer_irq_i(timer_irq), .soft_irq_i(soft_irq),
      .irq_pending_o(irq_pending), .mtvec_o(mtvec), .mepc_o(mepc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // One request on the next rising edge; returns #1 after it with the response visible
   task automatic acc(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
      csr_req   = 1'b1;
      csr_op    = op;
      csr_addr  = addr;
      csr_wdata = wd;
      @(posedge clk); #1;
      csr_req   = 1'b0;
      csr_op    = 2'b00;
      csr_wdata = '0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; csr_req = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
      instret = 0; trap = 0; trap_cause = 0; trap_pc = 0; mret = 0;
      ext_irq = 0; timer_irq = 0; soft_irq = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", csr_rdata, 32'h0);
      check("rst_valid", 32'(csr_valid), 32'h0);
      check("rst_illegal", 32'(csr_illegal), 32'h0);
      check("rst_irq", 32'(irq_pending), 32'h0);
      check("rst_mtvec", mtvec, 32'h0);
      check("rst_mepc", mepc, 32'h0);
      rst = 1'b0;

      acc(2'b01, 12'h340, 32'hDEAD_BEEF);
      check("scratch_rw_valid", 32'(csr_valid), 32'h1);
      check("scratch_rw_old", csr_rdata, 32'h0);
      acc(2'b00, 12'h340, 32'h0);
      check("scratch_rd", csr_rdata, 32'hDEAD_BEEF);
      check("scratch_rd_valid", 32'(csr_valid), 32'h1);
      idle();
      check("valid_one_cycle", 32'(csr_valid), 32'h0);

      acc(2'b00, 12'h300, 32'h0);
      check("mstatus_reset", csr_rdata, 32'h0000_1800);
      acc(2'b01, 12'h300, 32'hFFFF_FFFF);
      acc(2'b00, 12'h300, 32'h0);
      check("mstatus_mask", csr_rdata, 32'h0000_1888);
      acc(2'b01, 12'h300, 32'h0000_0008);
      acc(2'b00, 12'h300, 32'h0);
      check("mstatus_mie", csr_rdata, 32'h0000_1808);

      trap = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h0000_1003;
      idle();
      trap = 1'b0;
      check("trap_mepc", mepc, 32'h0000_1000);
      acc(2'b00, 12'h342, 32'h0);
      check("trap_mcause", csr_rdata, 32'h8000_000B);
      acc(2'b00, 12'h300, 32'h0);
      check("trap_mstatus", csr_rdata, 32'h0000_1880);
      mret = 1'b1;
      idle();
      mret = 1'b0;
      acc(2'b00, 12'h300, 32'h0);
      check("mret_mstatus", csr_rdata, 32'h0000_1888);

      acc(2'b01, 12'h305, 32'h1234_5677);
      check("mtvec_bit1", mtvec, 32'h1234_5675);
      acc(2'b10, 12'h305, 32'h0000_0002);
      check("mtvec_set_old", csr_rdata, 32'h1234_5675);
      check("mtvec_set_masked", mtvec, 32'h1234_5675);
      acc(2'b11, 12'h305, 32'h0000_0070);
      check("mtvec_clear", mtvec, 32'h1234_5605);

      acc(2'b01, 12'hF14, 32'h5);
      check("ro_write_illegal", 32'(csr_illegal), 32'h1);
      check("ro_write_rdata", csr_rdata, 32'h0);
      acc(2'b00, 12'h7C0, 32'h0);
      check("unimpl_illegal", 32'(csr_illegal), 32'h1);
      check("unimpl_rdata", csr_rdata, 32'h0);
      acc(2'b00, 12'hF14, 32'h0);
      check("hartid_legal", 32'(csr_illegal), 32'h0);
      check("hartid_val", csr_rdata, 32'h0);
      acc(2'b01, 12'h301, 32'h0);
      check("misa_wr_legal", 32'(csr_illegal), 32'h0);
      acc(2'b00, 12'h301, 32'h0);
      check("misa_val", csr_rdata, 32'h4000_0100);

`ifdef CSR_COUNTERS_EN
      acc(2'b01, 12'hB80, 32'h0);
      acc(2'b01, 12'hB00, 32'hFFFF_FFFF);
      idle();
      acc(2'b00, 12'hB80, 32'h0);
      check("mcycleh_carry", csr_rdata, 32'h1);
      acc(2'b00, 12'hB00, 32'h0);
      check("mcycle_wrap", csr_rdata, 32'h1);
      acc(2'b01, 12'hB02, 32'hFFFF_FFFE);
      acc(2'b01, 12'hB82, 32'h7);
      instret = 1'b1;
      repeat (3) idle();
      instret = 1'b0;
      acc(2'b00, 12'hB02, 32'h0);
      check("minstret_lo", csr_rdata, 32'h1);
      acc(2'b00, 12'hB82, 32'h0);
      check("minstret_hi", csr_rdata, 32'h8);
`else
      acc(2'b01, 12'hB00, 32'h5);
      check("mcycle_wr_legal", 32'(csr_illegal), 32'h0);
      acc(2'b00, 12'hB00, 32'h0);
      check("mcycle_zero", csr_rdata, 32'h0);
      instret = 1'b1;
      acc(2'b00, 12'hB82, 32'h0);
      instret = 1'b0;
      check("minstreth_zero", csr_rdata, 32'h0);
`endif

      acc(2'b10, 12'h304, 32'h0000_0800);
      acc(2'b01, 12'h300, 32'h0000_0008);
      check("irq_idle", 32'(irq_pending), 32'h0);
      ext_irq = 1'b1;
      #1;
      check("irq_lag", 32'(irq_pending), 32'h0);
      idle();
      check("irq_pending", 32'(irq_pending), 32'h1);
      acc(2'b00, 12'h344, 32'h0);
      check("mip_ext", csr_rdata, 32'h0000_0800);
      acc(2'b11, 12'h304, 32'h0000_0800);
      idle();
      check("irq_cleared", 32'(irq_pending), 32'h0);
      ext_irq = 1'b0;

      trap = 1'b1; trap_cause = 32'h2; trap_pc = 32'h0000_2002;
      acc(2'b01, 12'h341, 32'h0000_5554);
      trap = 1'b0;
      check("collide_valid", 32'(csr_valid), 32'h1);
      check("collide_old", csr_rdata, 32'h0000_1000);
      check("collide_mepc", mepc, 32'h0000_2000);

      csr_req = 1'b1; csr_op = 2'b00; csr_addr = 12'h340;
      #2 rst = 1'b1;
      #1;
      check("async_mtvec", mtvec, 32'h0);
      @(posedge clk); #1;
      csr_req = 1'b0;
      check("async_no_resp", 32'(csr_valid), 32'h0);
      rst = 1'b0;
      acc(2'b00, 12'h340, 32'h0);
      check("async_scratch", csr_rdata, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
